// File: rtl/exibe_sequencia_pkg.sv
// exibe_sequencia_pkg: state codes and default timings shared by the sequence display and the game controller
package exibe_sequencia_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'h0,
        PREP    = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;
    localparam int ON_CYCLES_DEF  = 1000;
    localparam int OFF_CYCLES_DEF = 500;
endpackage

// File: rtl/exibe_sequencia_contador_m.sv
// contador_m: modulo-M counter that saturates at M-1
// ports: clock, reset (async, active-low), zera (sync clear), conta (count enable),
//        q (count value), fim (q == M-1)
module contador_m #(
    parameter int M = 4,
    parameter int W = $clog2(M) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);
    logic [W-1:0] cnt_q;
    assign q   = cnt_q;
    assign fim = cnt_q == W'(M - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (zera)
            cnt_q <= '0;
        else if (conta && !fim)
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored sequence on the LEDs, entries 0..limite, each lit then dark
// ports: clock, reset (async, active-low), iniciar (start, sampled in IDLE), limite (last index),
//        mem_dado/endereco (async-read sequence memory), leds, exibindo (busy), pronto (done pulse),
//        db_estado (state code)
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int OFF_CYCLES = OFF_CYCLES_DEF,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);
    localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;
    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] end_q, end_d, lim_q, lim_d;
    logic [TW-1:0]     tmr;
    logic              tmr_fim, fase, done;
    // one timer serves both phases: the longer phase ends on the counter's own
    // terminal count, the shorter one on an explicit compare against its length
    assign fase = estado_q == ACENDE || estado_q == APAGA;
    assign done = tmr_fim || tmr == TW'((estado_q == ACENDE ? ON_CYCLES : OFF_CYCLES) - 1);
    contador_m #(.M(MAXC), .W(TW)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (!fase || done),
        .conta (fase),
        .q     (tmr),
        .fim   (tmr_fim)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            end_q    <= '0;
            lim_q    <= '0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            lim_q    <= lim_d;
        end
    end
    always_comb begin
        estado_d = estado_q;
        end_d    = end_q;
        lim_d    = lim_q;
        unique case (estado_q)
            IDLE:    estado_d = iniciar ? PREP : IDLE;
            PREP: begin
                end_d    = '0;
                lim_d    = limite;
                estado_d = ACENDE;
            end
            ACENDE:  estado_d = done ? APAGA : ACENDE;
            APAGA:   estado_d = done ? PROXIMO : APAGA;
            PROXIMO: begin
                estado_d = end_q == lim_q ? FIM : ACENDE;
                end_d    = end_q == lim_q ? end_q : end_q + 1'b1;
            end
            FIM:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end
    assign endereco  = end_q;
    assign leds      = estado_q == ACENDE ? mem_dado : '0;
    assign exibindo  = !(estado_q == IDLE || estado_q == FIM);
    assign pronto    = estado_q == FIM;
    assign db_estado = estado_q;
endmodule
